// File: rtl/aes_result_display.sv
`default_nettype none
// ============================================================================
// Module      : aes_result_display
// Description : Shows a 128-bit AES result as hexadecimal on an 8-digit,
//               common-anode 7-segment display. The value is shown as four
//               32-bit pages, most significant page first. Each page is held
//               for PAGE_CYCLES clocks. The eight digits are scanned, and each
//               digit is enabled for DIGIT_CYCLES clocks.
// Ports       : clk      - system clock, rising edge
//               rst_n    - asynchronous active-low reset
//               data_in  - 128-bit value to display, sampled live
//               an[7:0]  - digit enables, active-low, an[0] is rightmost
//               seg[6:0] - segments gfedcba, active-low
//               page[1:0]- index of the page currently on the pins
// Revision    : 1.0 - initial release
// ============================================================================
module aes_result_display #(
    parameter int DIGIT_CYCLES = 100000,
    parameter int PAGE_CYCLES  = 500000000
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [127:0] data_in,
    output logic [7:0]   an,
    output logic [6:0]   seg,
    output logic [1:0]   page
);

    // Counter widths never drop below one bit so a cycle count of 1 is legal.
    localparam int DW = (DIGIT_CYCLES > 1) ? $clog2(DIGIT_CYCLES) : 1;
    localparam int PW = (PAGE_CYCLES  > 1) ? $clog2(PAGE_CYCLES)  : 1;
    localparam logic [DW-1:0] DIGIT_LAST = DW'(DIGIT_CYCLES - 1);
    localparam logic [PW-1:0] PAGE_LAST  = PW'(PAGE_CYCLES - 1);

    logic [DW-1:0] digit_cnt_q, digit_cnt_d;
    logic [2:0]    digit_idx_q, digit_idx_d;
    logic [PW-1:0] page_cnt_q,  page_cnt_d;
    logic [1:0]    page_idx_q,  page_idx_d;
    logic [7:0]    an_q,        an_d;
    logic [6:0]    seg_q,       seg_d;
    logic [1:0]    page_q,      page_d;

    logic          digit_wrap;
    logic          page_wrap;
    logic [31:0]   page_word;
    logic [3:0]    nibble;

    always_comb begin
        // The two timers are fully independent. If both wrap in the same
        // cycle, both indices simply advance together.
        digit_wrap  = (digit_cnt_q == DIGIT_LAST);
        page_wrap   = (page_cnt_q  == PAGE_LAST);

        digit_cnt_d = digit_wrap ? '0 : digit_cnt_q + DW'(1);
        digit_idx_d = digit_wrap ? digit_idx_q + 3'd1 : digit_idx_q;
        page_cnt_d  = page_wrap  ? '0 : page_cnt_q + PW'(1);
        page_idx_d  = page_wrap  ? page_idx_q + 2'd1 : page_idx_q;

        // Page 0 holds the most significant word.
        case (page_idx_q)
            2'd0:    page_word = data_in[127:96];
            2'd1:    page_word = data_in[95:64];
            2'd2:    page_word = data_in[63:32];
            default: page_word = data_in[31:0];
        endcase

        // Digit d shows nibble d, so the rightmost digit shows the LS nibble.
        nibble = page_word[{digit_idx_q, 2'b00} +: 4];

        an_d   = ~(8'b0000_0001 << digit_idx_q);
        page_d = page_idx_q;

        case (nibble)
            4'h0:    seg_d = 7'h40;
            4'h1:    seg_d = 7'h79;
            4'h2:    seg_d = 7'h24;
            4'h3:    seg_d = 7'h30;
            4'h4:    seg_d = 7'h19;
            4'h5:    seg_d = 7'h12;
            4'h6:    seg_d = 7'h02;
            4'h7:    seg_d = 7'h78;
            4'h8:    seg_d = 7'h00;
            4'h9:    seg_d = 7'h10;
            4'hA:    seg_d = 7'h08;
            4'hB:    seg_d = 7'h03;
            4'hC:    seg_d = 7'h46;
            4'hD:    seg_d = 7'h21;
            4'hE:    seg_d = 7'h06;
            default: seg_d = 7'h0E;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            digit_cnt_q <= '0;
            digit_idx_q <= 3'd0;
            page_cnt_q  <= '0;
            page_idx_q  <= 2'd0;
            an_q        <= 8'hFF;
            seg_q       <= 7'h7F;
            page_q      <= 2'd0;
        end else begin
            digit_cnt_q <= digit_cnt_d;
            digit_idx_q <= digit_idx_d;
            page_cnt_q  <= page_cnt_d;
            page_idx_q  <= page_idx_d;
            an_q        <= an_d;
            seg_q       <= seg_d;
            page_q      <= page_d;
        end
    end

    // an, seg and page come from one register stage, so they always agree.
    assign an   = an_q;
    assign seg  = seg_q;
    assign page = page_q;

endmodule
`default_nettype wire

// File: tb/tb_aes_result_display.sv
`default_nettype none
// ============================================================================
// Module      : tb_aes_result_display
// Description : Directed self-checking bench for aes_result_display. It has
//               two instances: A uses 4/64 cycle timing and B uses 1/8.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_aes_result_display;

    localparam logic [127:0] VEC = 128'h29C3505F571420F6402299B31A02D73A;

    logic         clk;
    logic         rst_a_n, rst_b_n;
    logic [127:0] data_a,  data_b;
    logic [7:0]   an_a,    an_b;
    logic [6:0]   seg_a,   seg_b;
    logic [1:0]   page_a,  page_b;

    int n_cmp = 0;
    int n_bad = 0;
    int ka    = 0;
    int kb    = 0;

    aes_result_display #(.DIGIT_CYCLES(4), .PAGE_CYCLES(64)) dut_a (
        .clk     (clk),
        .rst_n   (rst_a_n),
        .data_in (data_a),
        .an      (an_a),
        .seg     (seg_a),
        .page    (page_a)
    );

    aes_result_display #(.DIGIT_CYCLES(1), .PAGE_CYCLES(8)) dut_b (
        .clk     (clk),
        .rst_n   (rst_b_n),
        .data_in (data_b),
        .an      (an_b),
        .seg     (seg_b),
        .page    (page_b)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    function automatic logic [6:0] hex7(input logic [3:0] v);
        case (v)
            4'h0: return 7'h40;  4'h1: return 7'h79;
            4'h2: return 7'h24;  4'h3: return 7'h30;
            4'h4: return 7'h19;  4'h5: return 7'h12;
            4'h6: return 7'h02;  4'h7: return 7'h78;
            4'h8: return 7'h00;  4'h9: return 7'h10;
            4'hA: return 7'h08;  4'hB: return 7'h03;
            4'hC: return 7'h46;  4'hD: return 7'h21;
            4'hE: return 7'h06;  default: return 7'h0E;
        endcase
    endfunction

    task automatic step_a();
        @(posedge clk); #1; ka++;
    endtask

    task automatic step_b();
        @(posedge clk); #1; kb++;
    endtask

    task automatic test_reset();
        rst_a_n = 1'b0; rst_b_n = 1'b0;
        data_a = '0; data_b = VEC;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            data_a = i[0] ? VEC : ~VEC;
            @(posedge clk); #1;
            n_cmp++; if (an_a !== 8'hFF) begin n_bad++; $display("FAIL reset_an: got %h want ff", an_a); end
            n_cmp++; if (seg_a !== 7'h7F) begin n_bad++; $display("FAIL reset_seg: got %h want 7f", seg_a); end
            n_cmp++; if (page_a !== 2'd0) begin n_bad++; $display("FAIL reset_page: got %0d want 0", page_a); end
        end
        n_cmp++; if (an_b !== 8'hFF) begin n_bad++; $display("FAIL reset_an_b: got %h want ff", an_b); end
        @(negedge clk);
        data_a = VEC; rst_a_n = 1'b1; ka = 0;
        step_a();
        n_cmp++; if (an_a !== 8'hFE) begin n_bad++; $display("FAIL first_an: got %h want fe", an_a); end
        n_cmp++; if (seg_a !== 7'h0E) begin n_bad++; $display("FAIL first_seg: got %h want 0e", seg_a); end
        n_cmp++; if (page_a !== 2'd0) begin n_bad++; $display("FAIL first_page: got %0d want 0", page_a); end
    endtask

    // Page 0 word 29C3505F, digit 0..7 shows F,5,0,5,3,C,9,2.
    task automatic test_page0();
        logic [6:0] p0 [8];
        logic [7:0] exp_an;
        int d;
        p0 = '{7'h0E, 7'h12, 7'h40, 7'h12, 7'h30, 7'h46, 7'h10, 7'h24};
        while (ka < 32) begin
            step_a();
            d = (ka - 1) / 4;
            exp_an = ~(8'b0000_0001 << d);
            n_cmp++; if (an_a !== exp_an) begin n_bad++; $display("FAIL page0_an[%0d]: got %h want %h", ka, an_a, exp_an); end
            n_cmp++; if (seg_a !== p0[d]) begin n_bad++; $display("FAIL page0_seg[%0d]: got %h want %h", ka, seg_a, p0[d]); end
        end
        n_cmp++; if (an_a !== 8'h7F) begin n_bad++; $display("FAIL page0_digit7_an: got %h want 7f", an_a); end
        n_cmp++; if (seg_a !== 7'h24) begin n_bad++; $display("FAIL page0_digit7_seg: got %h want 24", seg_a); end
    endtask

    task automatic test_digit_wrap();
        step_a();
        n_cmp++; if (an_a !== 8'hFE) begin n_bad++; $display("FAIL wrap_an: got %h want fe", an_a); end
        n_cmp++; if (seg_a !== 7'h0E) begin n_bad++; $display("FAIL wrap_seg: got %h want 0e", seg_a); end
        n_cmp++; if (page_a !== 2'd0) begin n_bad++; $display("FAIL wrap_page: got %0d want 0", page_a); end
    endtask

    task automatic test_page_seq();
        logic [1:0] exp_pg;
        while (ka < 257) begin
            step_a();
            exp_pg = 2'(((ka - 1) / 64) % 4);
            n_cmp++; if (page_a !== exp_pg) begin n_bad++; $display("FAIL page_seq[%0d]: got %0d want %0d", ka, page_a, exp_pg); end
            if (ka == 65) begin
                n_cmp++; if (an_a !== 8'hFE || seg_a !== 7'h02) begin n_bad++; $display("FAIL page1_d0: got an=%h seg=%h want an=fe seg=02", an_a, seg_a); end
            end
            if (ka == 193) begin
                n_cmp++; if (an_a !== 8'hFE || seg_a !== 7'h08) begin n_bad++; $display("FAIL page3_d0: got an=%h seg=%h want an=fe seg=08", an_a, seg_a); end
            end
        end
    endtask

    task automatic test_decode();
        logic [3:0] nib;
        for (int n = 0; n < 16; n++) begin
            nib = n[3:0];
            @(negedge clk);
            data_a = {32{nib}};
            for (int i = 0; i < 32; i++) begin
                step_a();
                n_cmp++; if (seg_a !== hex7(nib)) begin n_bad++; $display("FAIL decode_%h[%0d]: got %h want %h", nib, i, seg_a, hex7(nib)); end
            end
        end
        @(negedge clk);
        data_a = {32{4'h3}};
        step_a();
        n_cmp++; if (seg_a !== 7'h30) begin n_bad++; $display("FAIL live_3: got %h want 30", seg_a); end
        @(negedge clk);
        data_a = {32{4'hC}};
        step_a();
        n_cmp++; if (seg_a !== 7'h46) begin n_bad++; $display("FAIL live_C: got %h want 46", seg_a); end
    endtask

    task automatic test_simul_wrap_reset();
        logic [127:0] tmp;
        logic [7:0]   exp_an;
        logic [1:0]   exp_pg;
        logic [3:0]   nib;
        int d, p;
        @(negedge clk);
        rst_b_n = 1'b1; kb = 0;
        for (int i = 0; i < 40; i++) begin
            step_b();
            d = (kb - 1) % 8;
            p = ((kb - 1) / 8) % 4;
            exp_an = ~(8'b0000_0001 << d);
            exp_pg = 2'(p);
            tmp = VEC >> (32 * (3 - p));
            nib = tmp[4*d +: 4];
            n_cmp++; if (an_b !== exp_an) begin n_bad++; $display("FAIL fast_an[%0d]: got %h want %h", kb, an_b, exp_an); end
            n_cmp++; if (page_b !== exp_pg) begin n_bad++; $display("FAIL fast_page[%0d]: got %0d want %0d", kb, page_b, exp_pg); end
            n_cmp++; if (seg_b !== hex7(nib)) begin n_bad++; $display("FAIL fast_seg[%0d]: got %h want %h", kb, seg_b, hex7(nib)); end
        end
        // Run into page 1 mid-scan, then pulse reset between clock edges.
        for (int i = 0; i < 3; i++) step_b();
        #2;
        rst_b_n = 1'b0;
        #1;
        n_cmp++; if (an_b !== 8'hFF) begin n_bad++; $display("FAIL async_an: got %h want ff", an_b); end
        n_cmp++; if (seg_b !== 7'h7F) begin n_bad++; $display("FAIL async_seg: got %h want 7f", seg_b); end
        n_cmp++; if (page_b !== 2'd0) begin n_bad++; $display("FAIL async_page: got %0d want 0", page_b); end
        @(negedge clk);
        rst_b_n = 1'b1; kb = 0;
        step_b();
        n_cmp++; if (an_b !== 8'hFE || page_b !== 2'd0 || seg_b !== 7'h0E) begin
            n_bad++; $display("FAIL restart0: got an=%h page=%0d seg=%h want fe/0/0e", an_b, page_b, seg_b);
        end
        step_b();
        n_cmp++; if (an_b !== 8'hFD || seg_b !== 7'h12) begin
            n_bad++; $display("FAIL restart1: got an=%h seg=%h want fd/12", an_b, seg_b);
        end
    endtask

    initial begin
        test_reset();
        test_page0();
        test_digit_wrap();
        test_page_seq();
        test_decode();
        test_simul_wrap_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/aes_result_display.md
Name: aes_result_display

Overview:
- Display driver that shows a 128-bit AES result on an 8-digit, common-anode 7-segment display as hexadecimal.
- The 128-bit value is split into four 32-bit pages. Each page is shown for a fixed interval, and the 8 digits are time-multiplexed.
- Sits between the AES core's data_out and the board's an/seg pins.
- Generates its own digit-scan and page-advance timing from the single system clock.

Parameters:
- DIGIT_CYCLES, default 100000: clk cycles each digit stays enabled (1 kHz scan at 100 MHz). Legal range is 1 or more.
- PAGE_CYCLES, default 500000000: clk cycles each 32-bit page is shown (5 s at 100 MHz). Legal range is 1 or more.

Ports:
- clk  input  1: system clock; all logic on the rising edge.
- rst_n  input  1: asynchronous, active-low reset.
- data_in  input  128: value to display, typically the AES ciphertext. Sampled live, not latched.
- an  output  8: digit enables, active-low. an[0] is the rightmost digit.
- seg  output  7: segments, active-low, seg[0]=a, seg[1]=b, ... seg[6]=g.
- page  output  2: index of the page currently shown.

Behaviour:
- Reset (rst_n=0, asynchronous)
  - Digit counter, digit index, page counter and page index all clear to 0.
  - Outputs: an=8'hFF (all digits off), seg=7'h7F (all segments off), page=0.
- Digit timer
  - Free-running counter 0..DIGIT_CYCLES-1.
  - On the cycle it equals DIGIT_CYCLES-1, it wraps to 0 and the digit index increments: 0..7, then 7 wraps to 0.
- Page timer
  - Independent free-running counter 0..PAGE_CYCLES-1.
  - On wrap, the page index increments: 0..3, then 3 wraps to 0.
  - When both timers wrap in the same cycle, both indices advance in that cycle with no interaction.
- Page mapping (most significant first)
  - Page 0 = data_in[127:96], page 1 = [95:64], page 2 = [63:32], page 3 = [31:0].
- Digit mapping
  - Digit d shows nibble d of the page word: word[4d+3:4d].
  - Digit 0 (an[0], rightmost) shows the least significant nibble, so the page reads naturally left to right.
- Outputs are registered, with one-cycle latency from index state to pins.
  - an = ~(8'b1 << digit_index); exactly one bit is low at all times after reset.
  - seg = hex pattern of the selected nibble.
  - page = page index, registered in the same stage as an/seg so all three stay coherent.
  - The first edge after reset release drives an=8'hFE.
- Hex patterns (seg[6:0] = gfedcba, active-low): 0=40, 1=79, 2=24, 3=30, 4=19, 5=12, 6=02, 7=78, 8=00, 9=10, A=08, b=03, C=46, d=21, E=06, F=0E.
- Changes on data_in appear on seg one clock later; no glitch suppression or capture is required.
- Reset asserted mid-scan immediately forces the reset values. Scanning restarts from digit 0, page 0 after release.
- No other state; there is no handshake.

Test Plan:
- Reset check: hold rst_n=0 with data_in toggling -> an=FF, seg=7F, page=0 throughout. After release -> an=FE on the first edge.
- Page 0 display: DIGIT_CYCLES=4, PAGE_CYCLES=64, data_in=128'h29C3505F571420F6402299B31A02D73A. Expect:
  - digit 0: an=FE, seg=0E ('F');
  - digit 1: seg=12 ('5');
  - digit 7: an=7F, seg=24 ('2').
  - Each digit is held exactly 4 cycles.
- Digit wrap: same setup -> after 32 cycles the digit index returns to 0 (an=FE), still on page 0.
- Page sequencing and wrap: same setup, run 256 cycles.
  - page steps 0,1,2,3,0 every 64 cycles.
  - Page 1, digit 0 shows '6' (seg=02); page 3, digit 0 shows 'A' (seg=08).
- Full decode and live data: for each n in 0..F, set data_in to 128 bits of nibble n repeated.
  - seg equals the table entry one cycle later on every digit.
  - Changing data_in mid-digit updates seg on the next clock.
- Simultaneous wrap and reset: DIGIT_CYCLES=1, PAGE_CYCLES=8.
  - digit advances every clock; page advances on cycles where both timers wrap.
  - Pulsing rst_n low mid-run returns outputs to FF/7F asynchronously, then scanning restarts at an=FE, page=0.
